// File: rtl/ahb2apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb2apb_pkg
// Shared definitions for the AHB-to-APB read path: the read-assembly FSM
// state type and the helpers that derive the lane count (RATIO) and the lane
// index width (IDX_W) from the two bus widths.
// ---------------------------------------------------------------------------
package ahb2apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } asm_state_e;

    // Number of APB beats that make up one AHB word.
    function automatic int ratio_f(input int ahb_dw, input int apb_dw);
        return ahb_dw / apb_dw;
    endfunction

    // Lane index width; kept at least 1 so RATIO==1 still has a legal port.
    function automatic int idx_w_f(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/data_reg.sv
// ---------------------------------------------------------------------------
// data_reg
// One W-bit storage lane with a load enable. Clearing is done by the owner
// loading zero, so the only reset path is the asynchronous one.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, clears the lane
//   i_load : capture i_d this cycle
//   i_d    : data to capture
//   o_q    : stored lane value
// ---------------------------------------------------------------------------
module data_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (i_load) begin
            data_q <= i_d;
        end
    end

    assign o_q = data_q;

endmodule

// File: rtl/hrdata_assembler.sv
// ---------------------------------------------------------------------------
// hrdata_assembler
// Gathers RATIO = AHB_DW/APB_DW narrow APB read beats into one AHB read word.
// A read starts at lane i_start_beat and walks upward with wrap-around; with
// BIG_ENDIAN=1 the lane order is mirrored. A slave error ends the read early
// and leaves a sticky o_err.
//   clk, rst      : clock / asynchronous active-high reset
//   i_start       : begin an assembly (ignored while collecting)
//   i_start_beat  : first lane index, sampled with an accepted i_start
//   i_num_beats   : beat count, 0 or >RATIO means RATIO
//   i_beat_valid  : i_PRDATA / i_PSLVERR hold a finished APB beat
//   i_PRDATA      : APB read data
//   i_PSLVERR     : APB slave error for this beat
//   i_abort       : drop the current assembly, no completion pulse
//   o_HRDATA      : assembled word, held until the next accepted start
//   o_done        : one-cycle completion pulse
//   o_err         : sticky error of the last assembly
//   o_busy        : collecting beats
// ---------------------------------------------------------------------------
module hrdata_assembler
    import ahb2apb_pkg::*;
#(
    parameter int  AHB_DW     = 32,
    parameter int  APB_DW     = 8,
    parameter bit  BIG_ENDIAN = 1'b0,
    localparam int RATIO      = ratio_f(AHB_DW, APB_DW),
    localparam int IDX_W      = idx_w_f(RATIO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [IDX_W-1:0]  i_start_beat,
    input  logic [IDX_W:0]    i_num_beats,
    input  logic              i_beat_valid,
    input  logic [APB_DW-1:0] i_PRDATA,
    input  logic              i_PSLVERR,
    input  logic              i_abort,
    output logic [AHB_DW-1:0] o_HRDATA,
    output logic              o_done,
    output logic              o_err,
    output logic              o_busy
);

    localparam int NBW = IDX_W + 1;

    asm_state_e                   state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [NBW-1:0]               rem_q;
    logic                         done_q;
    logic                         err_q;

    logic                         start_acc;
    logic                         beat_acc;
    logic [NBW-1:0]               num_beats_d;
    logic [IDX_W-1:0]             start_idx_d;
    logic [IDX_W-1:0]             idx_d;
    logic [IDX_W-1:0]             lane_sel;
    logic [RATIO-1:0]             lane_load;
    logic [APB_DW-1:0]            lane_d;
    logic [RATIO-1:0][APB_DW-1:0] lane_q;

    assign start_acc = i_start && (state_q != ST_COLLECT);
    // Abort wins over a beat arriving in the same cycle.
    assign beat_acc  = (state_q == ST_COLLECT) && i_beat_valid && !i_abort;

    assign num_beats_d = ((i_num_beats == '0) || (i_num_beats > NBW'(RATIO)))
                       ? NBW'(RATIO) : i_num_beats;

    // With a single lane the index is always 0 whatever the port says.
    assign start_idx_d = (RATIO == 1) ? '0 : i_start_beat;
    assign idx_d       = (RATIO == 1) ? '0 : idx_q + IDX_W'(1);

    assign lane_sel = BIG_ENDIAN ? (IDX_W'(RATIO - 1) - idx_q) : idx_q;

    // A start loads zero into every lane; otherwise a lane takes beat data.
    assign lane_d = start_acc ? '0 : i_PRDATA;

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign lane_load[g] = start_acc || (beat_acc && (lane_sel == IDX_W'(g)));

        data_reg #(.W(APB_DW)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_load (lane_load[g]),
            .i_d    (lane_d),
            .o_q    (lane_q[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_q <= ST_COLLECT;
                        idx_q   <= start_idx_d;
                        rem_q   <= num_beats_d;
                        err_q   <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                    end else if (i_beat_valid) begin
                        idx_q <= idx_d;
                        rem_q <= rem_q - NBW'(1);
                        if (i_PSLVERR) begin
                            err_q <= 1'b1;
                        end
                        // done_q rises together with entry into DONE.
                        if ((rem_q == NBW'(1)) || i_PSLVERR) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_HRDATA = lane_q;
    assign o_done   = done_q;
    assign o_err    = err_q;
    assign o_busy   = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_hrdata_assembler.sv
// ---------------------------------------------------------------------------
// tb_hrdata_assembler
// Drives one little-endian and one big-endian instance with the same inputs.
// The reference keeps the beats of the current read in a queue and rebuilds
// the expected word from them; directed reads pin it with literal words.
// ---------------------------------------------------------------------------
module tb_hrdata_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_start_beat = '0;
    logic [2:0]  i_num_beats = '0;
    logic        i_beat_valid = 1'b0;
    logic [7:0]  i_PRDATA = '0;
    logic        i_PSLVERR = 1'b0;
    logic        i_abort = 1'b0;

    logic [31:0] hr_le, hr_be;
    logic        done_le, done_be, err_le, err_be, busy_le, busy_be;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    hrdata_assembler #(.AHB_DW(32), .APB_DW(8), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .i_start(i_start), .i_start_beat(i_start_beat),
        .i_num_beats(i_num_beats), .i_beat_valid(i_beat_valid), .i_PRDATA(i_PRDATA),
        .i_PSLVERR(i_PSLVERR), .i_abort(i_abort), .o_HRDATA(hr_le), .o_done(done_le),
        .o_err(err_le), .o_busy(busy_le)
    );

    hrdata_assembler #(.AHB_DW(32), .APB_DW(8), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .i_start(i_start), .i_start_beat(i_start_beat),
        .i_num_beats(i_num_beats), .i_beat_valid(i_beat_valid), .i_PRDATA(i_PRDATA),
        .i_PSLVERR(i_PSLVERR), .i_abort(i_abort), .o_HRDATA(hr_be), .o_done(done_be),
        .o_err(err_be), .o_busy(busy_be)
    );

    // ---------------- reference ----------------
    bit         m_busy, m_done, m_err;
    int         m_start, m_n;
    logic [7:0] m_beats[$];

    function automatic logic [31:0] assemble(input bit be);
        logic [31:0] w;
        int lane;
        w = '0;
        for (int k = 0; k < m_beats.size(); k++) begin
            lane = (m_start + k) % 4;
            if (be) lane = 3 - lane;
            w[lane*8 +: 8] = m_beats[k];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_start = 0; m_n = 0;
        m_beats.delete();
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (i_start) begin
                    m_busy  = 1;
                    m_start = int'(i_start_beat);
                    m_n     = (i_num_beats == 0 || i_num_beats > 4) ? 4 : int'(i_num_beats);
                    m_err   = 0;
                    m_beats.delete();
                end
            end else if (i_abort) begin
                m_busy = 0;
            end else if (i_beat_valid) begin
                m_beats.push_back(i_PRDATA);
                if (i_PSLVERR) m_err = 1;
                if (m_beats.size() == m_n || i_PSLVERR) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        chk("hrdata_le", hr_le, assemble(1'b0));
        chk("hrdata_be", hr_be, assemble(1'b1));
        chk("done_le", {31'd0, done_le}, {31'd0, m_done});
        chk("done_be", {31'd0, done_be}, {31'd0, m_done});
        chk("err_le", {31'd0, err_le}, {31'd0, m_err});
        chk("err_be", {31'd0, err_be}, {31'd0, m_err});
        chk("busy_le", {31'd0, busy_le}, {31'd0, m_busy});
        chk("busy_be", {31'd0, busy_be}, {31'd0, m_busy});
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic start_rd(input int sb, input int nb);
        i_start = 1'b1; i_start_beat = 2'(sb); i_num_beats = 3'(nb);
        step();
        i_start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input bit e);
        i_beat_valid = 1'b1; i_PRDATA = d; i_PSLVERR = e;
        step();
        i_beat_valid = 1'b0; i_PSLVERR = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_hr_le"}, hr_le, 32'h0);
        chk({tag, "_hr_be"}, hr_be, 32'h0);
        chk({tag, "_done"}, {31'd0, done_le}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_le}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_le}, 32'd0);
    endtask

    initial begin
        // reset state
        #1 rst = 1'b1;
        model_reset();
        #2 chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        // full little/big-endian read
        start_rd(0, 4);
        chk("busy_after_start", {31'd0, busy_le}, 32'd1);
        beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
        chk("full_le", hr_le, 32'h44332211);
        chk("full_be", hr_be, 32'h11223344);
        chk("full_done", {31'd0, done_le}, 32'd1);
        chk("full_err", {31'd0, err_le}, 32'd0);
        step();
        chk("full_done_once", {31'd0, done_le}, 32'd0);
        chk("full_hold", hr_le, 32'h44332211);

        // partial read from lane 2
        start_rd(2, 2);
        beat(8'hAA, 0); beat(8'hBB, 0);
        chk("part_le", hr_le, 32'hBBAA0000);
        chk("part_done", {31'd0, done_le}, 32'd1);

        // wrap from lane 3 to lane 0
        start_rd(3, 2);
        beat(8'h5A, 0); beat(8'hA5, 0);
        chk("wrap_le", hr_le, 32'h5A0000A5);

        // slave error on beat 2 ends the read; later beats ignored
        start_rd(0, 4);
        beat(8'h11, 0); beat(8'h22, 1);
        chk("err_done", {31'd0, done_le}, 32'd1);
        chk("err_flag", {31'd0, err_le}, 32'd1);
        chk("err_le", hr_le, 32'h00002211);
        beat(8'h33, 0);
        chk("err_hold", hr_le, 32'h00002211);
        chk("err_sticky", {31'd0, err_le}, 32'd1);

        // abort after one beat
        start_rd(0, 4);
        beat(8'h11, 0);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("abort_busy", {31'd0, busy_le}, 32'd0);
        chk("abort_done", {31'd0, done_le}, 32'd0);
        chk("abort_keep", hr_le, 32'h00000011);
        step();
        chk("abort_no_done", {31'd0, done_le}, 32'd0);

        // n=0 means a full read; start at lane 1
        start_rd(1, 0);
        beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
        chk("n0_le", hr_le, 32'h03020104);
        chk("n0_done", {31'd0, done_le}, 32'd1);

        // reset in the middle of a read
        start_rd(0, 4);
        beat(8'h11, 0);
        #2 rst = 1'b1;
        model_reset();
        #1 chk_zero_outputs("midrst");
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        step();
        chk("midrst_no_done", {31'd0, done_le}, 32'd0);
        start_rd(0, 4);
        beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
        chk("after_rst_le", hr_le, 32'h44332211);
        chk("after_rst_done", {31'd0, done_le}, 32'd1);

        // randomized traffic
        repeat (3000) begin
            i_start      = ($urandom_range(0, 3) == 0);
            i_start_beat = 2'($urandom_range(0, 3));
            i_num_beats  = 3'($urandom_range(0, 7));
            i_beat_valid = ($urandom_range(0, 2) != 0);
            i_PRDATA     = 8'($urandom);
            i_PSLVERR    = ($urandom_range(0, 15) == 0);
            i_abort      = ($urandom_range(0, 19) == 0);
            step();
        end
        i_start = 1'b0; i_beat_valid = 1'b0; i_PSLVERR = 1'b0; i_abort = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
